axis_pkt_fifo: RTL and testbench
================================

Name: axis_pkt_fifo

Overview:
- Store-and-forward packet buffer directly downstream of the tlast framing stage.
- Accepts framed 128-bit AXIS beats and releases a packet to the DMA only after its tlast beat has been written.
- The upstream framing stage has no tready input, so this block never backpressures. A packet that cannot fit is dropped whole, never truncated.
- Drop and occupancy status go to the control registers.

Parameters:
- DATA_W, 128, tdata width in bits.
- ADDR_W, 11, log2 of buffer depth in beats (2048 beats).
- CNT_W, 16, width of the packet and drop counters.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_W  input beat data.
- s_axis_tlast  in  1  last beat of an input packet.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  low in reset, high at all other times.
- m_axis_tdata  out  DATA_W  output beat data.
- m_axis_tlast  out  1  last beat of an output packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- i_clear_stats  in  1  one-cycle pulse; clears o_drop_count and o_overflow.
- o_pkt_count  out  CNT_W  committed packets not yet fully read out.
- o_drop_count  out  CNT_W  packets dropped; saturates at all-ones.
- o_overflow  out  1  sticky; set on any drop.

Behaviour:
- Reset (async assert, sync release):
  - All pointers, counters, drop state and the output register clear.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_pkt_count=0, o_drop_count=0, o_overflow=0, s_axis_tready=0.
  - Reset mid-packet discards all buffered and partial data. No partial packet survives.
- Storage:
  - Simple dual-port memory of 2^ADDR_W x (DATA_W+1), holding {tlast, tdata}.
  - One-cycle registered read.
- Pointers:
  - ADDR_W+1 bits each: wr_ptr, wr_commit, rd_ptr.
  - full when wr_ptr - rd_ptr == 2^ADDR_W.
  - Packet available when rd_ptr != wr_commit.
- Write FSM: states ACCEPT, DROP.
  - ACCEPT, beat with tvalid=1 and not full: write at wr_ptr, increment wr_ptr.
  - If that beat has tlast=1: wr_commit <= wr_ptr+1 on the same edge, and o_pkt_count increments.
  - ACCEPT, beat with tvalid=1 and full: beat discarded, wr_ptr <= wr_commit (rewind), go to DROP.
  - Exception to the above: if the full beat has tlast=1, count the drop immediately and stay in ACCEPT.
  - DROP: discard every beat. On a tlast beat, increment o_drop_count (saturating), set o_overflow, return to ACCEPT.
  - A packet longer than 2^ADDR_W beats is always dropped.
  - A single-beat packet (tlast on first beat) is legal.
- Read side:
  - Prefetch one beat into the output register whenever the register is empty, or is being consumed (m_axis_tvalid & m_axis_tready), and rd_ptr != wr_commit.
  - Full throughput: one beat per cycle while tready stays high.
  - Output register holds stable while tvalid=1 and tready=0 (AXIS rule).
  - o_pkt_count decrements when a beat with m_axis_tlast=1 is accepted.
- Latency:
  - First beat of a packet appears on m_axis with tvalid=1 exactly 2 cycles after the edge that accepted its tlast beat, when the buffer was previously empty and idle.
- Simultaneous events:
  - Commit and tlast readout in the same cycle leave o_pkt_count unchanged.
  - Full is evaluated against rd_ptr before the current cycle's read (conservative).
  - i_clear_stats coincident with a drop event: clear wins; the count becomes 0.
- Ordering:
  - Packets are output in arrival order, beats unmodified.
  - Dropped packets leave no residue.

Decomposition:
- Package pi_axis_pkg holds:
  - AXIS_DATA_W = 128.
  - Write-FSM enum wr_state_t {ACCEPT, DROP}.
  - Beat struct axis_beat_t {logic tlast; logic [AXIS_DATA_W-1:0] tdata;}.
- One sub-module: sdp_ram (parameterised width/depth, registered read, infers block RAM).
- Pointer, FSM and output register logic stay in the top.

Test Plan (ADDR_W=4, 16 beats, for directed tests):
1. Reset, then one 4-beat packet with data 1..4 and tready=1 -> m_axis beats 1..4, tlast on 4. First tvalid 2 cycles after tlast accepted. o_pkt_count goes 0->1->0.
2. tready=0 while 3 packets of 4 beats are written -> o_pkt_count=3, no drops. Then tready=1 -> 12 beats in order at 1 beat/cycle, tlast on beats 4, 8 and 12.
3. tready=0, write a 12-beat packet, then an 8-beat packet -> second packet dropped entirely, o_drop_count=1, o_overflow=1. Readout yields exactly 12 beats.
4. 20-beat packet into an empty buffer -> dropped, o_drop_count increments, nothing output. A following 2-beat packet is output intact.
5. Assert axis_aresetn=0 mid-packet after 3 beats plus 1 committed packet -> all outputs 0 immediately. After release, a new 1-beat packet is output alone, with tlast=1.
6. i_clear_stats pulsed in the same cycle as a drop's tlast -> o_drop_count=0, o_overflow=0. Committed packets are unaffected.

Source files
------------

// File: rtl/pi_axis_pkg.sv
// Shared types for the AXIS packet buffer: beat width, write-side FSM states and stored beat layout.
package pi_axis_pkg;

   localparam int unsigned AXIS_DATA_W = 128;

   typedef enum logic [0:0] {ACCEPT, DROP} wr_state_t;

   typedef struct packed {
      logic                   tlast;
      logic [AXIS_DATA_W-1:0] tdata;
   } axis_beat_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read data holds when idle.
module sdp_ram #(
   parameter int unsigned WIDTH  = 129,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXIS packet buffer: packets become readable only once their tlast beat is
// stored, and a packet that cannot fit is discarded whole since the source cannot be stalled.
module axis_pkt_fifo
   import pi_axis_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              axis_aclk,
   input  logic              axis_aresetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   input  logic              i_clear_stats,
   output logic [CNT_W-1:0]  o_pkt_count,
   output logic [CNT_W-1:0]  o_drop_count,
   output logic              o_overflow
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   wr_state_t       wr_state;
   logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr;
   logic            full, wr_en, commit, rewind, drop_evt;
   logic            avail, rd_en, pipe_valid, out_load, out_pop, rd_last;
   logic [DATA_W:0] ram_rdata;

   assign s_axis_tready = axis_aresetn;

   // Write-side decode; full is judged against rd_ptr before this cycle's read.
   always_comb begin
      full     = (wr_ptr - rd_ptr) == DEPTH;
      wr_en    = 1'b0;
      commit   = 1'b0;
      rewind   = 1'b0;
      drop_evt = 1'b0;
      if (s_axis_tvalid) begin
         unique case (wr_state)
            ACCEPT: begin
               if (!full) begin
                  wr_en  = 1'b1;
                  commit = s_axis_tlast;
               end else begin
                  rewind   = 1'b1;
                  drop_evt = s_axis_tlast;
               end
            end
            DROP:    drop_evt = s_axis_tlast;
            default: ;
         endcase
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         wr_state  <= ACCEPT;
         wr_ptr    <= '0;
         wr_commit <= '0;
      end else begin
         unique case (wr_state)
            ACCEPT: begin
               if (wr_en) wr_ptr <= wr_ptr + 1'b1;
               if (commit) wr_commit <= wr_ptr + 1'b1;
               if (rewind) begin
                  wr_ptr <= wr_commit;
                  if (!s_axis_tlast) wr_state <= DROP;
               end
            end
            DROP:    if (drop_evt) wr_state <= ACCEPT;
            default: wr_state <= ACCEPT;
         endcase
      end
   end

   // Two-stage read path: RAM output register, then the AXIS output register.
   always_comb begin
      avail    = rd_ptr != wr_commit;
      out_pop  = m_axis_tvalid && m_axis_tready;
      out_load = pipe_valid && (!m_axis_tvalid || m_axis_tready);
      rd_en    = avail && (!pipe_valid || out_load);
      rd_last  = out_pop && m_axis_tlast;
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         rd_ptr        <= '0;
         pipe_valid    <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         pipe_valid <= rd_en || (pipe_valid && !out_load);
         if (out_load) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tlast, m_axis_tdata} <= ram_rdata;
         end else if (out_pop) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         o_pkt_count  <= '0;
         o_drop_count <= '0;
         o_overflow   <= 1'b0;
      end else begin
         case ({commit, rd_last})
            2'b10:   o_pkt_count <= o_pkt_count + 1'b1;
            2'b01:   o_pkt_count <= o_pkt_count - 1'b1;
            default: ;
         endcase
         if (i_clear_stats) begin
            o_drop_count <= '0;
            o_overflow   <= 1'b0;
         end else if (drop_evt) begin
            if (o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
            o_overflow <= 1'b1;
         end
      end
   end

   sdp_ram #(
      .WIDTH  (DATA_W + 1),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (axis_aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data ({s_axis_tlast, s_axis_tdata}),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (ram_rdata)
   );

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo with a 16-beat buffer: directed plan plus randomized
// packets scored against a queue-of-beats reference model.
module tb_axis_pkt_fifo;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int          DEPTH  = 16;

   logic              axis_aclk = 1'b0;
   logic              axis_aresetn = 1'b0;
   logic [DATA_W-1:0] s_axis_tdata = '0;
   logic              s_axis_tlast = 1'b0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic              i_clear_stats = 1'b0;
   logic [CNT_W-1:0]  o_pkt_count;
   logic [CNT_W-1:0]  o_drop_count;
   logic              o_overflow;

   always #5 axis_aclk = ~axis_aclk;

   axis_pkt_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .axis_aclk     (axis_aclk),
      .axis_aresetn  (axis_aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .i_clear_stats (i_clear_stats),
      .o_pkt_count   (o_pkt_count),
      .o_drop_count  (o_drop_count),
      .o_overflow    (o_overflow)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: committed beats awaiting readout, packet/drop counts, overflow flag.
   logic [DATA_W:0] exp_q [$];
   int              model_pkts = 0;
   int              model_drops = 0;
   logic            model_ovf = 1'b0;
   bit              rand_rdy = 1'b0;
   bit              use_rand = 1'b0;
   bit              hold_pending = 1'b0;
   logic [DATA_W:0] held = '0;
   int              dcount = 0;

   task automatic chk(input string tag, input logic [DATA_W:0] got, input logic [DATA_W:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // One clock: score the output handshake at the negedge, then advance to just after posedge.
   task automatic tick();
      logic [DATA_W:0] b;
      @(negedge axis_aclk);
      if (hold_pending) begin
         chk("hold_valid", m_axis_tvalid, 1);
         chk("hold_data", {m_axis_tlast, m_axis_tdata}, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL beat_extra observed=%0h expected=no beat", {m_axis_tlast, m_axis_tdata});
         end
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("beat", {m_axis_tlast, m_axis_tdata}, b);
            if (b[DATA_W]) model_pkts--;
         end
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tlast, m_axis_tdata};
      @(posedge axis_aclk);
      #1;
      if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [DATA_W-1:0] next_data();
      dcount++;
      if (use_rand) return {$urandom, $urandom, $urandom, dcount};
      return DATA_W'(dcount);
   endfunction

   // 1 = certainly fits, 0 = certainly dropped, 2 = depends on how many beats are prefetched.
   function automatic int classify(input int len);
      int q  = exp_q.size();
      int lo = (q > 2) ? q - 2 : 0;
      if (q + len <= DEPTH) return 1;
      if (lo + len > DEPTH) return 0;
      return 2;
   endfunction

   task automatic send_pkt(input int len, input int gap_max, input bit kept, input bit clr_last);
      logic [DATA_W:0] pkt [$];
      logic            lst;
      for (int i = 0; i < len; i++) begin
         lst = (i == len - 1);
         pkt.push_back({lst, next_data()});
         s_axis_tvalid = 1'b1;
         {s_axis_tlast, s_axis_tdata} = pkt[i];
         i_clear_stats = clr_last && lst;
         tick();
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         i_clear_stats = 1'b0;
         if (gap_max > 0 && !lst) repeat ($urandom_range(0, gap_max)) tick();
      end
      if (kept) begin
         foreach (pkt[j]) exp_q.push_back(pkt[j]);
         model_pkts++;
      end
      if (clr_last) begin
         model_drops = 0;
         model_ovf   = 1'b0;
      end else if (!kept) begin
         model_drops++;
         model_ovf = 1'b1;
      end
   endtask

   task automatic drain(input bit rnd);
      rand_rdy = rnd;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
      chk("drain_empty", exp_q.size(), 0);
      rand_rdy = 1'b0;
      m_axis_tready = 1'b1;
      repeat (4) tick();
      chk("pkt_count_idle", o_pkt_count, model_pkts);
   endtask

   task automatic check_stats(input string tag);
      chk({tag, "_pkt_count"}, o_pkt_count, model_pkts);
      chk({tag, "_drop_count"}, o_drop_count, model_drops);
      chk({tag, "_overflow"}, o_overflow, model_ovf);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt, len, c;
      repeat (3) @(posedge axis_aclk);
      #1;
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", {m_axis_tlast, m_axis_tdata}, 0);
      check_stats("rst");
      axis_aresetn = 1'b1;
      tick();
      chk("s_tready_run", s_axis_tready, 1);

      // 1: single packet latency and order
      m_axis_tready = 1'b1;
      send_pkt(4, 0, 1, 0);
      chk("t1_pkt_count_commit", o_pkt_count, 1);
      chk("t1_lat0", m_axis_tvalid, 0);
      tick();
      chk("t1_lat1", m_axis_tvalid, 0);
      tick();
      chk("t1_lat2", m_axis_tvalid, 1);
      chk("t1_first_beat", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
      drain(0);

      // 2: three buffered packets, then full-rate readout
      m_axis_tready = 1'b0;
      repeat (3) send_pkt(4, 0, 1, 0);
      repeat (3) tick();
      check_stats("t2");
      m_axis_tready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         tick();
         cnt++;
      end
      chk("t2_throughput", cnt, 12);
      drain(0);

      // 3: second packet overflows and is dropped whole
      m_axis_tready = 1'b0;
      send_pkt(12, 0, 1, 0);
      send_pkt(8, 0, 0, 0);
      check_stats("t3");
      drain(1);

      // 4: oversize packet into empty buffer, then a short one
      m_axis_tready = 1'b1;
      send_pkt(20, 0, 0, 0);
      check_stats("t4_oversize");
      send_pkt(2, 0, 1, 0);
      drain(0);
      check_stats("t4");

      // 5: reset with one committed packet and a partial one buffered
      m_axis_tready = 1'b0;
      send_pkt(1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = 1'b0;
         s_axis_tdata  = next_data();
         tick();
      end
      s_axis_tvalid = 1'b0;
      axis_aresetn = 1'b0;
      #1;
      chk("t5_m_tvalid", m_axis_tvalid, 0);
      chk("t5_m_data", {m_axis_tlast, m_axis_tdata}, 0);
      chk("t5_s_tready", s_axis_tready, 0);
      chk("t5_pkt_count", o_pkt_count, 0);
      chk("t5_drop_count", o_drop_count, 0);
      chk("t5_overflow", o_overflow, 0);
      exp_q.delete();
      model_pkts = 0;
      model_drops = 0;
      model_ovf = 1'b0;
      hold_pending = 1'b0;
      repeat (2) @(posedge axis_aclk);
      #1;
      axis_aresetn = 1'b1;
      tick();
      m_axis_tready = 1'b1;
      send_pkt(1, 0, 1, 0);
      drain(0);

      // 6: clear coincident with a drop's final beat
      m_axis_tready = 1'b0;
      send_pkt(20, 0, 0, 0);
      send_pkt(12, 0, 1, 0);
      send_pkt(8, 0, 0, 1);
      check_stats("t6");
      drain(1);

      // Randomized rounds with the reader stalled: drop decisions follow occupancy.
      use_rand = 1'b1;
      for (int r = 0; r < 8; r++) begin
         m_axis_tready = 1'b0;
         repeat ($urandom_range(1, 4)) begin
            len = $urandom_range(1, 20);
            c = classify(len);
            for (int k = 0; k < 50 && c == 2; k++) begin
               len = $urandom_range(1, 20);
               c = classify(len);
            end
            if (c == 2) begin
               len = 20;
               c = 0;
            end
            send_pkt(len, 2, c == 1, 0);
            chk("rnd_pkt_count", o_pkt_count, model_pkts);
         end
         check_stats("rnd_round");
         drain(1);
      end

      // Randomized streaming with a random reader: only packets that always fit are sent.
      rand_rdy = 1'b1;
      for (int p = 0; p < 30; p++) begin
         len = $urandom_range(1, 8);
         for (int w = 0; w < 200 && exp_q.size() + len > DEPTH; w++) tick();
         send_pkt(len, 1, exp_q.size() + len <= DEPTH, 0);
         chk("stream_pkt_count", o_pkt_count, model_pkts);
      end
      drain(1);
      check_stats("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
